mod_n_down_counter: RTL and testbench
=====================================

Name: mod_n_down_counter

Overview:
- Loadable synchronous MOD-N down counter. It is the count-down counterpart to the team's free-running MOD-15 up counter.
- Counts from a start value to 0, emits a one-cycle terminal-count pulse, then either stops (one-shot) or reloads to MOD-1 (auto-reload).
- Used as a programmable interval/delay timer next to the up counters in the counter library.

Parameters:
- WIDTH, 4, count register width in bits.
- MOD, 15, modulus; legal count range 0..MOD-1; requires 2 <= MOD <= 2**WIDTH.
- PRESCALE_DIV, 4, clock-enable divide ratio; used only when the optional feature is compiled in; requires >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable, sampled each rising edge.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value captured on load.
- start  in  1  begin counting from current q.
- auto_reload  in  1  1 = reload MOD-1 at terminal count; 0 = one-shot.
- q  out  WIDTH  current count.
- tc  out  1  terminal-count pulse.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Interface: one clock domain, clk. Reset is asynchronous, active-low (rst_n). All outputs are registered.
- Reset values: q = MOD-1, state = IDLE, tc = 0, busy = 0, done = 0, prescaler = 0.
- States:
  - IDLE: q holds.
  - RUN: counting.
  - DONE: q held at 0.
- Per-edge priority: load > start > count step.
- load (any state): q <= load_val; if load_val >= MOD, q <= MOD-1 (clamped). state <= IDLE. tc = 0.
- start (IDLE or DONE, no load): state <= RUN; q unchanged. start while in RUN is ignored.
  - Starting from DONE with q = 0: the first step is a terminal-count step.
- Step (RUN, en = 1):
  - If q != 0: q <= q-1.
  - If q == 0: tc <= 1 for exactly the next cycle.
    - auto_reload = 1: q <= MOD-1, stay in RUN.
    - auto_reload = 0: q stays 0, state <= DONE.
- en = 0 in RUN: q, state and tc are frozen, except that tc always self-clears after one cycle.
- auto_reload is sampled only at the terminal-count step.
- Latency:
  - start to first decrement: the first enabled edge after the edge that enters RUN.
  - One-shot from value V, en held high: tc is high V+1 enabled edges after entering RUN.
- Wrap-around: no arithmetic underflow; 0 goes to MOD-1 only via reload.
- busy = (state == RUN); done = (state == DONE); both registered with the state.
- Reset mid-count: immediate asynchronous return to the reset values; any in-flight tc is dropped.
- Simultaneous load and terminal-count step: load wins; no tc.

Optional Feature:
- Macro: MOD_N_DOWN_COUNTER_PRESCALE_EN.
- Defined: an internal prescaler counts enabled cycles 0..PRESCALE_DIV-1. A step occurs only on the enabled edge where the prescaler is at PRESCALE_DIV-1; the prescaler then wraps to 0.
- The prescaler clears on reset, load and start.
- Undefined: every enabled edge in RUN is a step; no prescaler logic is generated.

Decomposition:
- Shared package counter_pkg:
  - State enum: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - Constant COUNT_RESET_OFFSET = 1 (reset value MOD-1).
- One sub-module: mod_n_prescaler, the enable divider with clear input, instantiated only under the macro.
- Counter datapath and FSM stay in the top module.

Test Plan:
- Reset then release with no inputs -> q = 14, busy = 0, done = 0, tc = 0 for 20 cycles.
- load, load_val = 3; start; en = 1, auto_reload = 0 -> q sequence 3, 2, 1, 0; tc high one cycle; done = 1; q holds 0 afterwards.
- load_val = 15 (>= MOD) -> q = 14 (clamped). Then auto_reload = 1, run 30 enabled edges -> sequence 14..0, 14..0 with two tc pulses 15 steps apart; busy stays 1.
- Mid-count en toggling, pattern 1,0,0,1 -> q decrements only on the edges where en = 1.
- load asserted on the same edge as the zero step -> q = load_val, no tc. rst_n pulsed low for 1 ns mid-count -> q = 14 asynchronously.
- With MOD_N_DOWN_COUNTER_PRESCALE_EN and PRESCALE_DIV = 4, load_val = 2, start, en = 1 -> q changes every 4th edge; tc on edge 12 after start.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: FSM state encoding and reset offset.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Counters reset to MOD minus this offset (i.e. the top of the count range).
   localparam int unsigned COUNT_RESET_OFFSET = 1;

endpackage

// File: rtl/mod_n_prescaler.sv
// Clock-enable divider for mod_n_down_counter: emits one tick every DIV enabled cycles.
// Only built when MOD_N_DOWN_COUNTER_PRESCALE_EN is defined.
`ifdef MOD_N_DOWN_COUNTER_PRESCALE_EN
module mod_n_prescaler #(
   parameter int unsigned DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Count enabled cycles 0..DIV-1; clear has priority.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i & ~clr_i & (cnt_q == CntMax);

endmodule
`endif

// File: rtl/mod_n_down_counter.sv
// Loadable MOD-N down counter / interval timer with one-shot or auto-reload terminal count.
// Optional enable prescaler compiled in with MOD_N_DOWN_COUNTER_PRESCALE_EN.
module mod_n_down_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned MOD          = 15,
   parameter int unsigned PRESCALE_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   // Elaboration-time parameter legality.
   if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
      $error("MOD out of range for WIDTH");
   end
   if (PRESCALE_DIV < 2) begin : g_bad_div
      $error("PRESCALE_DIV must be at least 2");
   end

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - COUNT_RESET_OFFSET);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             start_ok;
   logic             step;

   // A start is honoured only outside RUN and only when no load shares the edge.
   assign start_ok = start & ~load & (state_q != RUN);

`ifdef MOD_N_DOWN_COUNTER_PRESCALE_EN
   logic ps_tick;

   mod_n_prescaler #(
      .DIV (PRESCALE_DIV)
   ) u_prescaler (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (en & (state_q == RUN)),
      .clr_i  (load | start_ok),
      .tick_o (ps_tick)
   );

   assign step = ps_tick;
`else
   assign step = en;
`endif

   // Next-state: load > start > count step; tc is a single-cycle pulse by default-clear.
   always_comb begin
      q_d     = q_q;
      state_d = state_q;
      tc_d    = 1'b0;
      if (load) begin
         q_d     = (32'(load_val) >= MOD) ? MaxVal : load_val;
         state_d = IDLE;
      end else if (start_ok) begin
         state_d = RUN;
      end else if (state_q == RUN && step) begin
         if (q_q != '0) begin
            q_d = q_q - WIDTH'(1);
         end else begin
            tc_d = 1'b1;
            if (auto_reload) begin
               q_d = MaxVal;
            end else begin
               state_d = DONE;
            end
         end
      end
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= MaxVal;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign tc   = tc_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Self-checking bench for mod_n_down_counter: behavioural model plus directed literal checks.
// Exercises the prescaled build when MOD_N_DOWN_COUNTER_PRESCALE_EN is defined.
module tb_mod_n_down_counter;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned MOD   = 15;
   localparam int unsigned PDIV  = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic             start = 1'b0;
   logic             auto_reload = 1'b0;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   mod_n_down_counter #(
      .WIDTH        (WIDTH),
      .MOD          (MOD),
      .PRESCALE_DIV (PDIV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .auto_reload (auto_reload),
      .q           (q),
      .tc          (tc),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 0 idle, 1 running, 2 finished; plain integer counting.
   int m_q = MOD - 1;
   int m_mode = 0;
   int m_tc = 0;
   int m_ps = 0;

   function automatic bit model_step(input int ps);
`ifdef MOD_N_DOWN_COUNTER_PRESCALE_EN
      return (ps == PDIV - 1);
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= MOD - 1;
         m_mode <= 0;
         m_tc <= 0;
         m_ps <= 0;
      end else begin
         m_tc <= 0;
         if (load) begin
            m_q <= (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
            m_mode <= 0;
            m_ps <= 0;
         end else if (start && m_mode != 1) begin
            m_mode <= 1;
            m_ps <= 0;
         end else if (m_mode == 1 && en) begin
            m_ps <= (m_ps + 1) % PDIV;
            if (model_step(m_ps)) begin
               if (m_q > 0) begin
                  m_q <= m_q - 1;
               end else begin
                  m_tc <= 1;
                  if (auto_reload) m_q <= MOD - 1;
                  else m_mode <= 2;
               end
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge out of reset.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("q", 32'(q), m_q);
         check("tc", 32'(tc), m_tc);
         check("busy", 32'(busy), (m_mode == 1) ? 1 : 0);
         check("done", 32'(done), (m_mode == 2) ? 1 : 0);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   int tc_at[$];

   initial begin
      repeat (2) tick();
      rst_n = 1'b1;
      chk_en = 1'b1;

`ifndef MOD_N_DOWN_COUNTER_PRESCALE_EN
      // Idle after reset: holds MOD-1.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_q", 32'(q), 14);
      end

      // One-shot from 3.
      load = 1'b1; load_val = 4'd3;
      tick();
      check("load3_q", 32'(q), 3);
      load = 1'b0; start = 1'b1; en = 1'b1; auto_reload = 1'b0;
      tick();
      check("start_busy", 32'(busy), 1);
      check("start_q", 32'(q), 3);
      start = 1'b0;
      tick(); check("os_q2", 32'(q), 2);
      tick(); check("os_q1", 32'(q), 1);
      tick(); check("os_q0", 32'(q), 0);
      check("os_no_tc_yet", 32'(tc), 0);
      tick(); check("os_tc", 32'(tc), 1); check("os_done", 32'(done), 1);
      tick(); check("os_tc_clear", 32'(tc), 0); check("os_hold0", 32'(q), 0);

      // Restart from DONE with q = 0: first step is terminal count.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); check("restart_tc", 32'(tc), 1); check("restart_done", 32'(done), 1);

      // Clamped load, then auto-reload for 30 enabled edges.
      load = 1'b1; load_val = 4'd15;
      tick();
      check("clamp_q", 32'(q), 14);
      load = 1'b0; auto_reload = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (tc) tc_at.push_back(i);
      end
      check("ar_pulses", tc_at.size(), 2);
      if (tc_at.size() == 2) begin
         check("ar_first_tc", tc_at[0], 15);
         check("ar_gap", tc_at[1] - tc_at[0], 15);
      end
      check("ar_busy", 32'(busy), 1);
      check("ar_q", 32'(q), 14);

      // en pattern 1,0,0,1; a start while running is ignored.
      en = 1'b1; start = 1'b1; tick(); check("en1_q", 32'(q), 13);
      en = 1'b0; start = 1'b0; tick(); check("en0a_q", 32'(q), 13);
      tick(); check("en0b_q", 32'(q), 13);
      en = 1'b1; tick(); check("en1b_q", 32'(q), 12);

      // Load on the zero step wins, no tc.
      load = 1'b1; load_val = 4'd2; tick();
      load = 1'b0; start = 1'b1; tick();
      start = 1'b0; tick(); tick();
      check("pre_zero_q", 32'(q), 0);
      load = 1'b1; load_val = 4'd5; tick();
      check("ld_zero_q", 32'(q), 5);
      check("ld_zero_tc", 32'(tc), 0);
      check("ld_zero_busy", 32'(busy), 0);

      // Asynchronous reset mid-count.
      load = 1'b0; start = 1'b1; tick();
      start = 1'b0; tick(); tick();
      check("pre_rst_q", 32'(q), 3);
      en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_q", 32'(q), 14);
      check("rst_async_busy", 32'(busy), 0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("post_rst_q", 32'(q), 14);
`else
      // Prescaled: load 2, start, en high; one step per PDIV enabled edges.
      load = 1'b1; load_val = 4'd2;
      tick();
      load = 1'b0; start = 1'b1; en = 1'b1; auto_reload = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 3) check("ps_q_e3", 32'(q), 2);
         if (i == 4) check("ps_q_e4", 32'(q), 1);
         if (i == 8) check("ps_q_e8", 32'(q), 0);
         if (tc) tc_at.push_back(i);
      end
      check("ps_pulses", tc_at.size(), 1);
      if (tc_at.size() == 1) check("ps_tc_edge", tc_at[0], 12);
      check("ps_done", 32'(done), 1);
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
